// File: rtl/div_sequencer_if.sv
// div_sequencer_if: execute-stage handshake between the pipeline and the iterative divider
interface div_sequencer_if #(parameter int DATA_WIDTH = 64);
  logic                  i_start;
  logic                  i_flush;
  logic [2:0]            i_func3;
  logic                  i_word;
  logic [DATA_WIDTH-1:0] i_src_1;
  logic [DATA_WIDTH-1:0] i_src_2;
  logic                  o_stall;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_result;
  modport master (output i_start, i_flush, i_func3, i_word, i_src_1, i_src_2,
                  input o_stall, o_done, o_result);
  modport slave (input i_start, i_flush, i_func3, i_word, i_src_1, i_src_2,
                 output o_stall, o_done, o_result);
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: radix-2 restoring divider with its own FSM for RV64M DIV/DIVU/REM/REMU and W variants
module div_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic i_clk,
  input logic i_arstn,
  div_sequencer_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam logic [DW-1:0] MIN_D = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0] quo, rem, dvd, dvs, result;
  logic sign_q, sign_r, op_rem, op_word;
  logic is_signed, is_rem, dz, ovf, special, accept, ge;
  logic [DW-1:0] a_ext, b_ext, a_abs, b_abs, spec_res, q_fin, rem_nx, fin_res;
  logic [DW:0] rem_sh;
  function automatic logic [DW-1:0] wext(input logic w, input logic [DW-1:0] v);
    return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction
  always_comb begin
    is_signed = bus.i_func3 == 3'd4 || bus.i_func3 == 3'd6;
    is_rem = bus.i_func3 == 3'd6 || bus.i_func3 == 3'd7;
    a_ext = bus.i_word ? {{HW{is_signed & bus.i_src_1[HW-1]}}, bus.i_src_1[HW-1:0]} : bus.i_src_1;
    b_ext = bus.i_word ? {{HW{is_signed & bus.i_src_2[HW-1]}}, bus.i_src_2[HW-1:0]} : bus.i_src_2;
    a_abs = is_signed && a_ext[DW-1] ? -a_ext : a_ext;
    b_abs = is_signed && b_ext[DW-1] ? -b_ext : b_ext;
    dz = b_ext == '0;
    ovf = is_signed && (&b_ext) && a_ext == (bus.i_word ? MIN_W : MIN_D);
    special = dz || ovf;
    spec_res = wext(bus.i_word, is_rem ? (dz ? a_ext : '0) : (dz ? '1 : a_ext));
    accept = state == IDLE && bus.i_start && !bus.i_flush;
    rem_sh = {rem, dvd[DW-1]};
    ge = rem_sh >= {1'b0, dvs};
    rem_nx = ge ? rem_sh[DW-1:0] - dvs : rem_sh[DW-1:0];
    q_fin = {quo[DW-2:0], ge};
    fin_res = wext(op_word, op_rem ? (sign_r ? -rem_nx : rem_nx) : (sign_q ? -q_fin : q_fin));
  end
  always_comb begin
    state_nx = state;
    bus.o_stall = 1'b0;
    bus.o_done = 1'b0;
    case (state)
      IDLE: begin
        bus.o_stall = accept;
        state_nx = accept ? (special ? FINISH : DIV) : IDLE;
      end
      DIV: begin
        bus.o_stall = !bus.i_flush;
        state_nx = bus.i_flush ? IDLE : (cnt == CNT_W'(1) ? FINISH : DIV);
      end
      FINISH: begin
        bus.o_done = !bus.i_flush;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_arstn)
    if (!i_arstn) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      op_rem <= 1'b0;
      op_word <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt <= bus.i_word ? CNT_W'(HW) : CNT_W'(DW);
      quo <= '0;
      rem <= '0;
      dvd <= bus.i_word ? {a_abs[HW-1:0], {HW{1'b0}}} : a_abs;
      dvs <= b_abs;
      sign_q <= is_signed && (a_ext[DW-1] ^ b_ext[DW-1]);
      sign_r <= is_signed && a_ext[DW-1];
      op_rem <= is_rem;
      op_word <= bus.i_word;
      if (special) result <= spec_res;
    end else if (state == DIV && !bus.i_flush) begin
      cnt <= cnt - CNT_W'(1);
      quo <= q_fin;
      rem <= rem_nx;
      dvd <= dvd << 1;
      if (cnt == CNT_W'(1)) result <= fin_res;
    end
  assign bus.o_result = result;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized scoreboard bench comparing the divider against an arithmetic reference
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {logic [63:0] res; int cyc;} exp_t;
  exp_t sb[$];

  div_sequencer_if #(.DATA_WIDTH(64)) bus ();
  div_sequencer #(.DATA_WIDTH(64), .CNT_W(7)) dut (.i_clk(clk), .i_arstn(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division in the active width, with the RISC-V special cases
  function automatic void ref_model(input logic [2:0] f, input logic w, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] res, output bit special);
    bit sgn, rm;
    logic [31:0] a32, b32, q32, r32, t32;
    logic [63:0] q, r;
    sgn = f == 3'd4 || f == 3'd6;
    rm = f == 3'd6 || f == 3'd7;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      special = b32 == 0 || (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
      if (b32 == 0) begin q32 = '1; r32 = a32; end
      else if (special) begin q32 = a32; r32 = '0; end
      else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      t32 = rm ? r32 : q32;
      res = {{32{t32[31]}}, t32};
    end else begin
      special = b == 0 || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
      if (b == 0) begin q = '1; r = a; end
      else if (special) begin q = a; r = '0; end
      else if (sgn) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
      res = rm ? r : q;
    end
  endfunction

  // mode: 0 normal, 1 flush in DIV at t+10, 2 flush in FINISH, 3 async reset at t+5
  task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int mode);
    logic [63:0] er;
    bit sp;
    int t, lat;
    ref_model(f, w, a, b, er, sp);
    lat = sp ? 1 : (w ? 33 : 65);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_func3 = f;
    bus.i_word = w;
    bus.i_src_1 = a;
    bus.i_src_2 = b;
    t = cyc;
    if (mode == 0) sb.push_back('{er, t + lat});
    #1 chk("stall_accept", 64'(bus.o_stall), 64'd1);
    for (int c = t + 1; c <= t + lat; c++) begin
      @(negedge clk);
      bus.i_start = 1'($urandom_range(0, 1));
      bus.i_func3 = 3'($urandom_range(0, 7));
      bus.i_word = 1'($urandom_range(0, 1));
      bus.i_src_1 = {$urandom, $urandom};
      bus.i_src_2 = {$urandom, $urandom};
      if (mode == 3 && c == t + 5) begin
        bus.i_start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_result", bus.o_result, 64'd0);
        chk("arst_done", 64'(bus.o_done), 64'd0);
        chk("arst_stall", 64'(bus.o_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      bus.i_flush = (mode == 1 && c == t + 10) || (mode == 2 && c == t + lat);
      #1 chk("stall_busy", 64'(bus.o_stall), 64'((c < t + lat) && !bus.i_flush));
      if (mode == 1 && c == t + 10) break;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_flush = 1'b0;
    end
  endtask

  function automatic logic [63:0] pick(input int k);
    case (k)
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 300));
      2: return -64'($urandom_range(1, 300));
      3: return 64'h8000_0000_0000_0000;
      4: return '0;
      5: return '1;
      6: return {$urandom, 32'h8000_0000};
      default: return 64'd1;
    endcase
  endfunction

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.o_done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(bus.o_done), 64'd0);
      else begin
        e = sb.pop_front();
        chk("result", bus.o_result, e.res);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_func3 = 3'd0;
    bus.i_word = 1'b0;
    bus.i_src_1 = '0;
    bus.i_src_2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", bus.o_result, 64'd0);
    chk("reset_done", 64'(bus.o_done), 64'd0);
    chk("reset_stall", 64'(bus.o_stall), 64'd0);
    rst_n = 1'b1;
    idle(2);
    run_op(3'd5, 1'b0, 64'd100, 64'd7, 0);
    run_op(3'd7, 1'b0, 64'd100, 64'd7, 0);
    run_op(3'd4, 1'b0, -64'd7, 64'd2, 0);
    run_op(3'd6, 1'b0, -64'd7, 64'd2, 0);
    run_op(3'd4, 1'b0, 64'd7, -64'd2, 0);
    run_op(3'd6, 1'b0, 64'd7, -64'd2, 0);
    idle(1);
    run_op(3'd4, 1'b0, 64'd42, 64'd0, 0);
    run_op(3'd7, 1'b0, 64'd42, 64'd0, 0);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(3'd4, 1'b1, 64'h1_8000_0000, 64'd1, 0);
    run_op(3'd5, 1'b1, 64'hFFFF_FFFF, 64'd2, 0);
    run_op(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op(3'd7, 1'b1, 64'h9000_0000, 64'd0, 0);
    run_op(3'd5, 1'b0, 64'd1000, 64'd3, 1);
    run_op(3'd5, 1'b0, 64'd100, 64'd7, 0);
    run_op(3'd7, 1'b1, 64'd12345, 64'd100, 2);
    idle(1);
    run_op(3'd4, 1'b0, 64'd999, 64'd10, 3);
    idle(2);
    for (int i = 0; i < 50; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             pick($urandom_range(0, 7)), pick($urandom_range(0, 7)), 0);
      idle($urandom_range(0, 2));
    end
    idle(1);
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative radix-2 divider with its own sequencing FSM for the RV64M DIV/DIVU/REM/REMU ops and their W variants.
- Sits beside the ALU in the execute stage and takes forwarded operands.
- Holds the pipeline with o_stall while it iterates, then presents a registered result for one cycle.
- Killed by pipeline flush (branch mispredict, trap).

Parameters:
DATA_WIDTH, 64, operand/result width; must be even; W mode operates on DATA_WIDTH/2.
CNT_W, 7, iteration counter width; must hold DATA_WIDTH.

Ports:
i_clk  input  1  clock
i_arstn  input  1  asynchronous active-low reset
i_start  input  1  execute-stage divide op valid; sampled only in IDLE
i_flush  input  1  kill in-flight op
i_func3  input  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; other codes treated as DIVU
i_word  input  1  W variant (32-bit op, sign-extended result)
i_src_1  input  DATA_WIDTH  dividend (forwarded rs1)
i_src_2  input  DATA_WIDTH  divisor (forwarded rs2)
o_stall  output  1  hold fetch/decode/execute
o_done  output  1  one-cycle result-valid pulse
o_result  output  DATA_WIDTH  quotient or remainder

Behaviour:
- Reset (i_arstn low, async):
  - state=IDLE; counter, quotient, remainder and o_result registers = 0.
  - o_done=0, o_stall=0.
- States: IDLE, DIV, FINISH.
- Operand prep in IDLE (combinational, latched on accept):
  - W mode: take the low 32 bits. Sign-extend them for signed ops (func3 4, 6); zero-extend them for unsigned ops.
  - Signed ops: record sign_q = sign(a)^sign(b) and sign_r = sign(a); latch |a| and |b|.
  - Unsigned ops: latch raw values.
- IDLE, i_start=1, i_flush=0:
  - Divisor==0 (in the active width) or signed overflow (dividend = most-negative value of the active width, divisor = -1): latch the special result and go to FINISH. Latency 1.
  - Otherwise: counter = active width (64, or 32 in W mode), remainder=0, go to DIV.
- IDLE, i_start=1 with i_flush=1: start ignored; remain in IDLE.
- DIV, one quotient bit per cycle:
  - Form rem' = {rem, dividend MSB}.
  - If rem' >= divisor (unsigned), subtract and shift in q=1; else shift in q=0.
  - Decrement counter; when the counter reaches 1 this cycle, go to FINISH.
  - Exactly active-width cycles are spent in DIV.
- Entering FINISH from DIV: negate the quotient if sign_q; negate the remainder if sign_r; select by func3 (DIV/DIVU = quotient, REM/REMU = remainder). Register this into o_result.
- W mode: o_result = sign-extension of bit 31 of the 32-bit result, for all four ops.
- FINISH: o_done=1 for exactly this one cycle; next state IDLE. A new i_start is accepted the following cycle.
- Special results:
  - Divide by zero: quotient = all ones; remainder = dividend (active width, then W extension).
  - Overflow: quotient = dividend; remainder = 0.
- o_stall (combinational):
  - High in IDLE when i_start && !i_flush.
  - High throughout DIV.
  - Low in FINISH, so the pipeline advances in the same cycle o_done pulses.
- Latency: accept at cycle t.
  - Normal op: o_done at t+W+1 (W=64 or 32).
  - Special case: o_done at t+1.
- Flush: i_flush=1 in DIV or FINISH forces IDLE next cycle.
  - In FINISH, o_done is forced low in the same cycle.
  - o_stall drops combinationally in the flush cycle.
  - o_result keeps its last value (don't-care when o_done=0).
- i_start in DIV/FINISH is ignored; the op in flight is unaffected.
- Async reset mid-operation: immediate return to the reset values; no o_done.
- Operand inputs may change after accept; all state uses latched copies.

Test Plan:
- DIVU 100/7 (DATA_WIDTH=64) -> o_stall high for cycles t..t+64, o_done at t+65, o_result=14; REMU same operands -> 2.
- DIV -7/2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM -7/2 -> -1; DIV 7/-2 -> -3; REM 7/-2 -> 1.
- DIV divisor 0, dividend 42 -> o_done at t+1, o_result=0xFFFF_FFFF_FFFF_FFFF; REMU by 0 -> 42.
- DIV 0x8000_0000_0000_0000 / -1 -> o_done at t+1, o_result=0x8000_0000_0000_0000; REM -> 0.
- DIVW i_src_1=0x1_8000_0000, i_src_2=1 -> o_done at t+33, o_result=0xFFFF_FFFF_8000_0000; DIVUW 0xFFFF_FFFF/2 -> 0x7FFF_FFFF.
- Flush at t+10 of a DIVU -> IDLE at t+11, no o_done; back-to-back i_start at t+11 completes normally. Assert i_arstn low at t+5 -> outputs 0 immediately.
